// File: rtl/led_pattern_sequencer_pkg.sv
// Shared board constants: clock rate, mode encoding, per-mode seed patterns.
package led_pattern_sequencer_pkg;

  localparam int BOARD_CLK_HZ = 12000000;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_KNIGHT = 2'd2,
    MODE_RING   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [7:0] SEED_BLINK  = 8'h00;
  localparam logic [7:0] SEED_COUNT  = 8'h00;
  localparam logic [7:0] SEED_KNIGHT = 8'h01;
  localparam logic [7:0] SEED_RING   = 8'h01;

  // Pattern loaded into the LEDs when a mode is entered.
  function automatic logic [7:0] mode_seed(input mode_t m);
    case (m)
      MODE_COUNT:  return SEED_COUNT;
      MODE_KNIGHT: return SEED_KNIGHT;
      MODE_RING:   return SEED_RING;
      default:     return SEED_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Single-cycle enable strobe every TICK_DIV clocks; restart realigns the period.
module tick_gen #(
  parameter int TICK_DIV = 12000000
) (
  input  logic BOARD_CLK,
  input  logic BOARD_RST,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1; the strobe is registered so it lands the cycle after LAST.
  always_ff @(posedge BOARD_CLK or posedge BOARD_RST) begin
    if (BOARD_RST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps one of four LED patterns per tick; a mode pulse cycles patterns, pause freezes.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TICK_DIV = BOARD_CLK_HZ,
  parameter int LED_W    = 8
) (
  input  logic             BOARD_CLK,
  input  logic             BOARD_RST,
  input  logic             mode_next,
  input  logic             pause,
  output logic [LED_W-1:0] BOARD_LED,
  output logic             tick,
  output logic [1:0]       mode
);

  localparam logic [LED_W-1:0] LED_TOP    = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LED_BOTTOM = LED_W'(1);

  mode_t            mode_q, mode_nxt;
  dir_t             dir_q, dir_nxt;
  logic [LED_W-1:0] led_q, led_nxt;
  logic [LED_W-1:0] shifted;

  // A mode pulse restarts the period so the new pattern gets a full tick before stepping.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .BOARD_CLK (BOARD_CLK),
    .BOARD_RST (BOARD_RST),
    .restart   (mode_next),
    .tick      (tick)
  );

  // State registers: mode, knight direction and LED image.
  always_ff @(posedge BOARD_CLK or posedge BOARD_RST) begin
    if (BOARD_RST) begin
      mode_q <= MODE_BLINK;
      dir_q  <= DIR_LEFT;
      led_q  <= '0;
    end else begin
      mode_q <= mode_nxt;
      dir_q  <= dir_nxt;
      led_q  <= led_nxt;
    end
  end

  // Next state: a mode change outranks a same-cycle tick; paused ticks are dropped.
  always_comb begin
    mode_nxt = mode_q;
    dir_nxt  = dir_q;
    led_nxt  = led_q;
    shifted  = '0;
    if (mode_next) begin
      mode_nxt = mode_t'(mode_q + 2'd1);
      led_nxt  = LED_W'(mode_seed(mode_nxt));
      dir_nxt  = DIR_LEFT;
    end else if (tick && !pause) begin
      case (mode_q)
        MODE_BLINK: led_nxt = ~led_q;
        MODE_COUNT: led_nxt = led_q + LED_W'(1);
        MODE_KNIGHT: begin
          shifted = (dir_q == DIR_LEFT) ? (led_q << 1) : (led_q >> 1);
          led_nxt = shifted;
          if (shifted == LED_TOP) begin
            dir_nxt = DIR_RIGHT;
          end else if (shifted == LED_BOTTOM) begin
            dir_nxt = DIR_LEFT;
          end
        end
        MODE_RING: led_nxt = {led_q[LED_W-2:0], led_q[LED_W-1]};
        default: led_nxt = led_q;
      endcase
    end
  end

  assign BOARD_LED = led_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with an expected-LED queue.
module tb_led_pattern_sequencer;

  localparam int TICK_DIV = 4;
  localparam int LED_W    = 8;

  logic             clk;
  logic             rst;
  logic             mode_next;
  logic             pause;
  logic [LED_W-1:0] board_led;
  logic             tick;
  logic [1:0]       mode;

  logic [LED_W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  led_pattern_sequencer #(.TICK_DIV(TICK_DIV), .LED_W(LED_W)) dut (
    .BOARD_CLK (clk),
    .BOARD_RST (rst),
    .mode_next (mode_next),
    .pause     (pause),
    .BOARD_LED (board_led),
    .tick      (tick),
    .mode      (mode)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode_next = 1'b0;
    pause = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_mode();
    mode_next = 1'b1;
    step();
    mode_next = 1'b0;
  endtask

  // Bounded wait for the tick strobe.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 3 * TICK_DIV) begin
      step();
      n++;
    end
    check({tag, "_tick_seen"}, tick, 1);
  endtask

  // Wait for a tick, then compare the LED one cycle later against the queue head.
  task automatic tick_and_check(input string tag);
    logic [LED_W-1:0] exp;
    wait_tick(tag);
    step();
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = 'x;
    end
    check(tag, board_led, exp);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    mode_next = 1'b0;
    pause = 1'b0;

    // Reset values
    do_reset();
    check("rst_led", board_led, 0);
    check("rst_tick", tick, 0);
    check("rst_mode", mode, 0);

    // BLINK: tick on cycles 4,8,..,20; LED toggles one cycle later
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int c = 1; c <= 21; c++) begin
      step();
      check("tick_phase", tick, (c % TICK_DIV == 0) ? 1 : 0);
      if (c > 1 && (c % TICK_DIV) == 1) begin
        check("blink", board_led, exp_q.pop_front());
      end
    end
    check("blink_mode", mode, 0);

    // COUNT: 260 ticks, wrap at tick 256
    do_reset();
    pulse_mode();
    check("count_mode", mode, 1);
    check("count_seed", board_led, 0);
    for (int i = 1; i <= 260; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 260; i++) tick_and_check("count");

    // KNIGHT: triangle sweep, period 14 ticks
    do_reset();
    pulse_mode();
    pulse_mode();
    check("knight_mode", mode, 2);
    check("knight_seed", board_led, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      int m;
      int pos;
      m = k % 14;
      pos = (m <= 7) ? m : 14 - m;
      exp_q.push_back(8'(1 << pos));
    end
    for (int k = 1; k <= 16; k++) tick_and_check("knight");

    // RING: rotate left, then wrap mode back to BLINK
    do_reset();
    pulse_mode();
    pulse_mode();
    pulse_mode();
    check("ring_mode", mode, 3);
    check("ring_seed", board_led, 8'h01);
    for (int k = 1; k <= 9; k++) exp_q.push_back(8'(1 << (k % 8)));
    for (int k = 1; k <= 9; k++) tick_and_check("ring");
    pulse_mode();
    check("wrap_mode", mode, 0);
    check("wrap_led", board_led, 8'h00);

    // Mode pulse coinciding with tick: tick discarded, period restarts
    do_reset();
    pulse_mode();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) tick_and_check("count_pre");
    wait_tick("collide");
    pulse_mode();
    check("collide_mode", mode, 2);
    check("collide_led", board_led, 8'h01);
    for (int c = 1; c <= TICK_DIV; c++) begin
      step();
      check("collide_tick", tick, (c == TICK_DIV) ? 1 : 0);
      check("collide_hold", board_led, 8'h01);
    end
    step();
    check("collide_step", board_led, 8'h02);

    // Pause in COUNT at 0x10: paused ticks dropped, resume on next tick
    do_reset();
    pulse_mode();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 16; i++) tick_and_check("count_pause_pre");
    pause = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_tick("pause");
      step();
      check("pause_hold", board_led, 8'h10);
    end
    pause = 1'b0;
    exp_q.push_back(8'h11);
    tick_and_check("resume");

    // Asynchronous reset mid-period, while tick is high
    wait_tick("async_rst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_led", board_led, 0);
    check("arst_tick", tick, 0);
    check("arst_mode", mode, 0);
    step();
    rst = 1'b0;

    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Downstream consumer of a 1 Hz time base on the Alhambra-ii (12 MHz BOARD_CLK).
- Generates its own single-cycle tick enable in the BOARD_CLK domain. No derived clocks.
- Steps one of four LED patterns once per tick.
- Mode is cycled by a pre-debounced push-button pulse; a pause level freezes the display.

Parameters:
- TICK_DIV, 12000000, BOARD_CLK cycles per tick. Must be >= 2. Benches use 4.
- LED_W, 8, number of LEDs. Patterns below are defined for 8.

Ports:
- BOARD_CLK  in  1  12 MHz board clock. Sole clock.
- BOARD_RST  in  1  asynchronous, active-high reset.
- mode_next  in  1  1-cycle synchronous pulse, already debounced: advance to next mode.
- pause      in  1  level: 1 = hold the pattern, tick generator keeps running.
- BOARD_LED  out LED_W  registered LED drive, bit0 = LED0.
- tick       out 1  registered 1-cycle strobe, once every TICK_DIV cycles.
- mode       out 2  current mode: 0 BLINK, 1 COUNT, 2 KNIGHT, 3 RING.

Behaviour:
- Reset (async assert, sync release):
  - BOARD_LED = 0x00, mode = 0, tick = 0, tick counter = 0, knight direction = LEFT.
  - First tick occurs TICK_DIV cycles after release.
- Tick generator:
  - Counter width is clog2(TICK_DIV). It counts 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 for the one cycle after the counter equals TICK_DIV-1.
  - Period is exactly TICK_DIV cycles, with no drift.
- Pattern step:
  - Occurs on a cycle where tick = 1 and pause = 0 and mode_next = 0.
  - BOARD_LED takes its new value on the following cycle (1-cycle latency from tick).
- BLINK: 0x00 <-> 0xFF toggle.
- COUNT: binary increment, 0xFF wraps to 0x00.
- KNIGHT:
  - Single lit bit. LEFT shifts left, RIGHT shifts right.
  - When the shift result is 0x80, direction becomes RIGHT. When it is 0x01, direction becomes LEFT.
  - Sequence: 0x01,0x02,...,0x80,0x40,...,0x01,0x02. Period 14 ticks.
- RING: rotate left, 0x80 -> 0x01.
- mode_next:
  - mode <= mode+1 mod 4, so 3 wraps to 0.
  - Next cycle loads the seed for the new mode: BLINK 0x00, COUNT 0x00, KNIGHT 0x01 with LEFT, RING 0x01.
  - Tick counter restarts at 0, so the first step of the new mode comes a full TICK_DIV cycles later.
- Simultaneous events:
  - mode_next together with tick: the mode change wins and the tick is discarded.
  - Mode change while pause = 1: seed still loads, and the pattern then holds.
- pause:
  - Ticks occurring while pause = 1 are dropped, not queued.
  - On release, stepping resumes on the next tick.
- Reset mid-pattern returns everything to reset values immediately.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (e.g. board_pkg) holds:
  - Mode encoding constants MODE_BLINK/COUNT/KNIGHT/RING.
  - Seed constants.
  - BOARD_CLK_HZ = 12000000.
- One sub-module, tick_gen (params TICK_DIV; ports BOARD_CLK, BOARD_RST, restart, tick). Reusable by other board blocks.
- Pattern/mode logic stays in the top.

Test Plan (TICK_DIV=4):
- Reset, then run 20 cycles -> tick high on cycles 4, 8, 12, 16, 20 after release. BLINK shows 0x00, 0xFF, 0x00, ... one cycle after each tick. mode = 0.
- One mode_next, then 260 ticks -> mode = 1. BOARD_LED counts 0x00..0xFF and wraps back to 0x00 at tick 256.
- Two mode_next pulses from reset, then 16 ticks -> BOARD_LED = 0x01,0x02,0x04,...,0x80,0x40,...,0x01,0x02,0x04. Direction flips exactly at 0x80 and 0x01.
- Three mode_next pulses, then 9 ticks -> 0x01,0x02,...,0x80,0x01,0x02. A fourth mode_next -> mode = 0, BOARD_LED = 0x00.
- mode_next asserted in the same cycle as tick while in COUNT at 0x05 -> mode = 2, BOARD_LED = 0x01, no step applied. Next tick comes 4 cycles after the pulse.
- In COUNT at 0x10: hold pause for 3 ticks -> stays 0x10. Release -> next tick gives 0x11. Assert BOARD_RST mid-period -> all outputs are 0 immediately.
